// File: rtl/multicycle_core_ctrl.sv
// Multi-cycle RV32I sequencer: fetch over req/gnt/rvalid, decode OP/OP-IMM, drive one datapath
// phase per state, and trap on illegal instructions or fetch timeouts.
module multicycle_core_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        resume,
    output logic [31:0] instr_q,
    output logic [31:0] pc,
    output logic        reg_write_en,
    output logic [3:0]  alu_ctrl,
    output logic        imm_en,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH, S_WAIT, S_DECODE, S_EXECUTE, S_WRITEBACK, S_TRAP
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam int              CNT_W    = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [3:0]       alu_ctrl_q;
    logic             imm_en_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       dec_legal;
    logic [3:0] dec_alu;
    logic       dec_imm;
    logic       wait_expired;

    assign opcode    = instr_q[6:0];
    assign funct3    = instr_q[14:12];
    assign funct7    = instr_q[31:25];
    assign imem_addr = pc;

    assign wait_expired = (state_q == S_WAIT) && !imem_rvalid && (wait_cnt_q == CNT_LAST);

    // For OP-IMM, instr[30] is an immediate bit; it only selects SRA for the shift-right form.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        dec_legal = 1'b0;
        dec_alu   = 4'b0000;
        dec_imm   = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                dec_alu   = {instr_q[30], funct3};
                dec_legal = (funct7 == F7_BASE) ||
                            ((funct7 == F7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OPC_OP_IMM: begin
                dec_imm = 1'b1;
                dec_alu = {1'b0, funct3};
                if (funct3 == 3'b001) begin
                    dec_legal = (funct7 == F7_BASE);
                end else if (funct3 == 3'b101) begin
                    dec_alu   = {instr_q[30], funct3};
                    dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                end else begin
                    dec_legal = 1'b1;
                end
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        imem_req     = 1'b0;
        reg_write_en = 1'b0;
        retire       = 1'b0;
        alu_ctrl     = 4'b0000;
        imm_en       = 1'b0;
        trap         = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid)       state_d = S_DECODE;
                else if (wait_expired) state_d = S_TRAP;
            end
            S_DECODE: begin
                if (dec_legal) begin
                    alu_ctrl = dec_alu;
                    imm_en   = dec_imm;
                    state_d  = S_EXECUTE;
                end else begin
                    state_d  = S_TRAP;
                end
            end
            S_EXECUTE: begin
                alu_ctrl = alu_ctrl_q;
                imm_en   = imm_en_q;
                state_d  = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                alu_ctrl     = alu_ctrl_q;
                imm_en       = imm_en_q;
                reg_write_en = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
                if (resume) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc         <= RESET_PC;
            instr_q    <= 32'h0000_0000;
            wait_cnt_q <= '0;
            alu_ctrl_q <= 4'b0000;
            imm_en_q   <= 1'b0;
            trap_cause <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_FETCH: begin
                    if (imem_gnt) wait_cnt_q <= '0;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                        if (wait_expired) trap_cause <= CAUSE_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        alu_ctrl_q <= dec_alu;
                        imm_en_q   <= dec_imm;
                    end else begin
                        trap_cause <= CAUSE_ILLEGAL;
                    end
                end
                S_WRITEBACK: begin
                    pc         <= pc + 32'd4;
                    alu_ctrl_q <= 4'b0000;
                    imm_en_q   <= 1'b0;
                end
                S_TRAP: begin
                    if (resume) begin
                        pc         <= pc + 32'd4;
                        trap_cause <= CAUSE_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// Bench for multicycle_core_ctrl: a memory responder drives fetches, a scoreboard queue holds the
// expected writeback of each legal instruction and a negedge monitor pops it on retire.
module tb_multicycle_core_ctrl;

    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;
    localparam logic [6:0]  OP       = 7'b0110011;
    localparam logic [6:0]  OP_IMM   = 7'b0010011;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu;
        logic        imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, resume = 1'b0;
    logic [31:0] imem_rdata = 32'h0;

    logic        imem_req, reg_write_en, imm_en, retire, trap;
    logic [31:0] imem_addr, instr_q, pc;
    logic [3:0]  alu_ctrl;
    logic [1:0]  trap_cause;

    logic        w_imem_req, w_reg_write_en, w_imm_en, w_retire, w_trap;
    logic [31:0] w_imem_addr, w_instr_q, w_pc;
    logic [3:0]  w_alu_ctrl;
    logic [1:0]  w_trap_cause;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_pc;
    exp_t        sb[$];

    always #5 clk = ~clk;

    multicycle_core_ctrl #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .resume(resume), .instr_q(instr_q), .pc(pc), .reg_write_en(reg_write_en),
        .alu_ctrl(alu_ctrl), .imm_en(imm_en), .retire(retire), .trap(trap),
        .trap_cause(trap_cause)
    );

    // Second instance starting one word below 2^32 to observe the PC wrap.
    multicycle_core_ctrl #(.RESET_PC(WRAP_PC), .IMEM_TIMEOUT(TIMEOUT)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .resume(resume), .instr_q(w_instr_q), .pc(w_pc), .reg_write_en(w_reg_write_en),
        .alu_ctrl(w_alu_ctrl), .imm_en(w_imm_en), .retire(w_retire), .trap(w_trap),
        .trap_cause(w_trap_cause)
    );

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && (retire || reg_write_en)) begin
            exp_t e;
            total++;
            if (retire !== 1'b1 || reg_write_en !== 1'b1) begin
                bad++;
                $display("FAIL wb_strobes got retire=%b we=%b exp 1/1", retire, reg_write_en);
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_retire pc=%h with empty scoreboard", pc);
            end else begin
                e = sb.pop_front();
                if (pc !== e.pc || alu_ctrl !== e.alu || imm_en !== e.imm) begin
                    bad++;
                    $display("FAIL retire_data got pc=%h alu=%b imm=%b exp pc=%h alu=%b imm=%b",
                             pc, alu_ctrl, imm_en, e.pc, e.alu, e.imm);
                end
            end
            total++;
            if ({w_imem_req, w_retire, w_reg_write_en, w_alu_ctrl, w_imm_en, w_trap, w_trap_cause,
                 w_instr_q} !== {imem_req, retire, reg_write_en, alu_ctrl, imm_en, trap,
                 trap_cause, instr_q} || w_imem_addr !== w_pc) begin
                bad++;
                $display("FAIL wrap_twin got retire=%b alu=%b exp retire=%b alu=%b",
                         w_retire, w_alu_ctrl, retire, alu_ctrl);
            end
        end
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL req_wait got imem_req=%b exp 1 within 20 cycles", imem_req);
        end
    endtask

    task automatic do_resume();
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (pc !== exp_pc || trap !== 1'b1 || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL trap_hold got pc=%h trap=%b req=%b exp pc=%h trap=1 req=0",
                         pc, trap, imem_req, exp_pc);
            end
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        exp_pc = exp_pc + 32'd4;
        total++;
        if (pc !== exp_pc || trap !== 1'b0 || trap_cause !== 2'b00 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL resume got pc=%h trap=%b cause=%b req=%b exp pc=%h 0 00 1",
                     pc, trap, trap_cause, imem_req, exp_pc);
        end
    endtask

    task automatic fetch(input logic [31:0] instr, input int gnt_dly, input int rv_dly,
                         input bit legal, input logic [3:0] exp_alu, input bit exp_imm);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        total++;
        if (imem_addr !== exp_pc) begin
            bad++;
            $display("FAIL fetch_addr got %h exp %h", imem_addr, exp_pc);
        end
        for (int i = 0; i < gnt_dly; i++) begin
            imem_gnt    = 1'b0;
            imem_rvalid = (i == 0);
            imem_rdata  = 32'h0000_006F;
            tick();
            imem_rvalid = 1'b0;
            total++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_q === 32'h0000_006F) begin
                bad++;
                $display("FAIL req_hold got req=%b addr=%h instr_q=%h exp req=1 addr=%h",
                         imem_req, imem_addr, instr_q, exp_pc);
            end
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        for (int i = 0; i < rv_dly; i++) begin
            total++;
            if (trap !== 1'b0 || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL wait_state got trap=%b req=%b exp 0/0 at wait cycle %0d",
                         trap, imem_req, i + 1);
            end
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = instr;
        if (legal) sb.push_back('{pc: exp_pc, alu: exp_alu, imm: exp_imm});
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        total++;
        if (instr_q !== instr) begin
            bad++;
            $display("FAIL instr_latch got %h exp %h", instr_q, instr);
        end
        tick();
        if (legal) begin
            total++;
            if (alu_ctrl !== exp_alu || imm_en !== exp_imm || reg_write_en !== 1'b0) begin
                bad++;
                $display("FAIL execute got alu=%b imm=%b we=%b exp alu=%b imm=%b we=0",
                         alu_ctrl, imm_en, reg_write_en, exp_alu, exp_imm);
            end
            tick();
            tick();
            exp_pc = exp_pc + 32'd4;
            total++;
            if (pc !== exp_pc || retire !== 1'b0 || reg_write_en !== 1'b0 || imem_req !== 1'b1) begin
                bad++;
                $display("FAIL post_wb got pc=%h retire=%b we=%b req=%b exp pc=%h 0 0 1",
                         pc, retire, reg_write_en, imem_req, exp_pc);
            end
        end else begin
            total++;
            if (trap !== 1'b1 || trap_cause !== 2'b01 || reg_write_en !== 1'b0 || pc !== exp_pc) begin
                bad++;
                $display("FAIL illegal_trap got trap=%b cause=%b we=%b pc=%h exp 1 01 0 %h",
                         trap, trap_cause, reg_write_en, pc, exp_pc);
            end
            do_resume();
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #22;
        total++;
        if (pc !== 32'h0 || instr_q !== 32'h0 || trap !== 1'b0 || trap_cause !== 2'b00 ||
            reg_write_en !== 1'b0 || retire !== 1'b0 || alu_ctrl !== 4'b0 || imm_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got pc=%h instr=%h trap=%b cause=%b we=%b alu=%b",
                     pc, instr_q, trap, trap_cause, reg_write_en, alu_ctrl);
        end
        total++;
        if (w_pc !== WRAP_PC) begin
            bad++;
            $display("FAIL reset_pc_param got %h exp %h", w_pc, WRAP_PC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_pc = 32'h0;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_fetch got req=%b addr=%h exp 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_add();
        fetch(32'h0020_81B3, 0, 0, 1'b1, 4'b0000, 1'b0);
        total++;
        if (w_pc !== 32'h0000_0000) begin
            bad++;
            $display("FAIL pc_wrap got %h exp 00000000", w_pc);
        end
    endtask

    task automatic test_sequence();
        fetch(32'h4020_8133, 0, 0, 1'b1, 4'b1000, 1'b0);
        fetch(32'h4030_D093, 0, 0, 1'b1, 4'b1101, 1'b1);
        fetch(32'hC000_8093, 0, 0, 1'b1, 4'b0000, 1'b1);
        fetch(enc(7'b0000000, 3'b110, OP),     0, 0, 1'b1, 4'b0110, 1'b0);
        fetch(enc(7'b0000000, 3'b011, OP),     0, 1, 1'b1, 4'b0011, 1'b0);
        fetch(enc(7'b0000000, 3'b001, OP),     0, 0, 1'b1, 4'b0001, 1'b0);
        fetch(enc(7'b0100000, 3'b101, OP),     1, 0, 1'b1, 4'b1101, 1'b0);
        fetch(enc(7'b0100000, 3'b100, OP_IMM), 0, 0, 1'b1, 4'b0100, 1'b1);
        fetch(enc(7'b0000000, 3'b010, OP_IMM), 0, 2, 1'b1, 4'b0010, 1'b1);
        fetch(enc(7'b0000000, 3'b101, OP_IMM), 0, 0, 1'b1, 4'b0101, 1'b1);
    endtask

    task automatic test_illegal();
        fetch(32'h0000_006F, 0, 0, 1'b0, 4'b0000, 1'b0);
        fetch(32'h4020_9133, 0, 0, 1'b0, 4'b0000, 1'b0);
        fetch(enc(7'b0000001, 3'b000, OP),     0, 0, 1'b0, 4'b0000, 1'b0);
        fetch(enc(7'b0100000, 3'b001, OP_IMM), 0, 0, 1'b0, 4'b0000, 1'b0);
        fetch(enc(7'b0000001, 3'b101, OP_IMM), 0, 0, 1'b0, 4'b0000, 1'b0);
        fetch(32'h0020_81B3, 0, 0, 1'b1, 4'b0000, 1'b0);
    endtask

    task automatic test_timeout();
        bit ok;
        wait_req(ok);
        if (!ok) return;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            total++;
            if (trap !== 1'b0) begin
                bad++;
                $display("FAIL early_timeout got trap=1 at wait cycle %0d exp 0", i + 1);
            end
            tick();
        end
        total++;
        if (trap !== 1'b1 || trap_cause !== 2'b10 || pc !== exp_pc) begin
            bad++;
            $display("FAIL timeout_trap got trap=%b cause=%b pc=%h exp 1 10 %h",
                     trap, trap_cause, pc, exp_pc);
        end
        do_resume();
        fetch(enc(7'b0000000, 3'b111, OP), 0, TIMEOUT - 1, 1'b1, 4'b0111, 1'b0);
    endtask

    task automatic test_gnt_delay();
        resume = 1'b1;
        tick();
        resume = 1'b0;
        total++;
        if (pc !== exp_pc || trap !== 1'b0) begin
            bad++;
            $display("FAIL stray_resume got pc=%h trap=%b exp %h 0", pc, trap, exp_pc);
        end
        fetch(enc(7'b0000000, 3'b100, OP), 3, 0, 1'b1, 4'b0100, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            fetch(enc(7'b0000000, 3'(i), OP_IMM == OP_IMM ? OP_IMM : OP), 0, 0, 1'b1,
                  {1'b0, 3'(i)}, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_req(ok);
        if (!ok) return;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (pc !== 32'h0 || w_pc !== WRAP_PC || reg_write_en !== 1'b0 || retire !== 1'b0 ||
            trap !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_wait got pc=%h wpc=%h we=%b retire=%b trap=%b exp 0 %h 0 0 0",
                     pc, w_pc, reg_write_en, retire, trap, WRAP_PC);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0020_81B3;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        exp_pc = 32'h0;
        sb.delete();
        total++;
        if (instr_q !== 32'h0 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL late_rvalid got instr_q=%h req=%b exp 00000000 1", instr_q, imem_req);
        end
        fetch(32'h0020_81B3, 0, 0, 1'b1, 4'b0000, 1'b0);

        wait_req(ok);
        if (!ok) return;
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h4020_8133;
        tick();
        imem_rvalid = 1'b0;
        tick();
        tick();
        total++;
        if (retire !== 1'b1 || reg_write_en !== 1'b1) begin
            bad++;
            $display("FAIL wb_reached got retire=%b we=%b exp 1 1", retire, reg_write_en);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (retire !== 1'b0 || reg_write_en !== 1'b0 || pc !== 32'h0 || alu_ctrl !== 4'b0) begin
            bad++;
            $display("FAIL reset_in_wb got retire=%b we=%b pc=%h alu=%b exp 0 0 0 0000",
                     retire, reg_write_en, pc, alu_ctrl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_pc = 32'h0;
        fetch(enc(7'b0000000, 3'b110, OP_IMM), 0, 0, 1'b1, 4'b0110, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_pc = 32'h0;
        test_reset();
        test_add();
        test_sequence();
        test_illegal();
        test_timeout();
        test_gnt_delay();
        test_back_to_back();
        test_reset_mid();
        repeat (2) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
